// File: rtl/double_dabble_sequencer.sv
// rtl/double_dabble_sequencer.sv - iterative binary-to-BCD converter, one bit per clock (optional DOUBLE_DABBLE_SEQ_BACK_TO_BACK_EN)
module double_dabble_sequencer #(
    parameter int BIN_WIDTH  = 16,
    parameter int BCD_DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_WIDTH-1:0]      in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*BCD_DIGITS-1:0]   out_bcd,
    output logic                      busy
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Reject configurations whose digit count cannot hold the largest input.
    if (BIN_WIDTH < 1 || BIN_WIDTH > 32) begin : g_bad_width
        $error("double_dabble_sequencer: BIN_WIDTH must be in 1..32");
    end
    if (pow10(BCD_DIGITS) <= ((64'd1 << BIN_WIDTH) - 64'd1)) begin : g_bad_digits
        $error("double_dabble_sequencer: BCD_DIGITS too small for BIN_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // Adjust every BCD digit (+3 when above 4) ahead of the shift; digits never carry.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (sr[BIN_WIDTH + 4*i +: 4] > 4'd4) begin
                sr_adj[BIN_WIDTH + 4*i +: 4] = sr[BIN_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Sequencer: load on accept, shift BIN_WIDTH times, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr         <= {{BCD_W{1'b0}}, in_data};
                        cnt        <= CNT_W'(BIN_WIDTH);
                        state      <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj << 1;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
`ifdef DOUBLE_DABBLE_SEQ_BACK_TO_BACK_EN
                        if (in_valid) begin
                            sr          <= {{BCD_W{1'b0}}, in_data};
                            cnt         <= CNT_W'(BIN_WIDTH);
                            state       <= SHIFT;
                            out_valid_q <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
`else
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef DOUBLE_DABBLE_SEQ_BACK_TO_BACK_EN
    // While a result is waiting, a new input can ride on the same handshake edge.
    assign in_ready = in_ready_q | (out_valid_q & out_ready);
`else
    assign in_ready = in_ready_q;
`endif

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_bcd   = sr[SR_W-1 -: BCD_W];

endmodule

// File: tb/tb_double_dabble_sequencer.sv
// tb/tb_double_dabble_sequencer.sv - self-checking bench for double_dabble_sequencer
module tb_double_dabble_sequencer;

    localparam int BW = 16;
    localparam int BD = 5;
`ifdef DOUBLE_DABBLE_SEQ_BACK_TO_BACK_EN
    localparam bit B2B     = 1'b1;
    localparam int SPACING = BW + 1;
`else
    localparam bit B2B     = 1'b0;
    localparam int SPACING = BW + 2;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [4*BD-1:0] out_bcd;
    logic          busy;

    int errors = 0;
    int checks = 0;

    double_dabble_sequencer #(.BIN_WIDTH(BW), .BCD_DIGITS(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Decimal digits by repeated division.
    function automatic logic [4*BD-1:0] to_bcd(input longint unsigned v);
        logic [4*BD-1:0] r;
        r = '0;
        for (int i = 0; i < BD; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Transaction-level model: a value is accepted, becomes available BW edges later,
    // and is held until taken.
    bit              m_busy = 1'b0;
    bit              m_done = 1'b0;
    int              m_left = 0;
    logic [4*BD-1:0] m_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy   = 1'b1;
                m_left   = BW;
                m_result = to_bcd(longint'(in_data));
            end
        end else if (!m_done) begin
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end else if (out_ready) begin
            if (B2B && in_valid) begin
                m_done   = 1'b0;
                m_left   = BW;
                m_result = to_bcd(longint'(in_data));
            end else begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
        #3;
        if (!rst) begin
            check("cyc_in_ready", {31'b0, in_ready},
                  {31'b0, (!m_busy) || (B2B && m_done && out_ready)});
            check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_done});
            check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            if (m_done) check("cyc_out_bcd", 32'(out_bcd), 32'(m_result));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Convert one value with out_ready held high; check latency, result, busy release.
    task automatic convert(input logic [BW-1:0] v, input logic [4*BD-1:0] exp, input string nm);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_accept"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = BW'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, 32'(n), 32'(BW));
        check({nm, "_bcd"}, 32'(out_bcd), 32'(exp));
        @(negedge clk);
        check({nm, "_busy_drop"}, {31'b0, busy}, 32'd0);
        check({nm, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    logic [BW-1:0]   vals [3];
    logic [4*BD-1:0] exps [3];
    int              rise [3];

    initial begin
        int n;
        int idx;
        int nres;
        bit prev;
        bit acc_pending;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state held while idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", {31'b0, in_ready}, 32'd1);
            check("rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_out_bcd", 32'(out_bcd), 32'd0);
        end

        convert(16'd65535, 20'h65535, "max");
        convert(16'd0,     20'h00000, "zero");
        convert(16'd9,     20'h00009, "nine");
        convert(16'd10,    20'h00010, "ten");
        convert(16'd40960, 20'h40960, "v40960");

        // Backpressure: result held with out_ready low; stray in_valid pulses ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd1234;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd999;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 4);
            in_data  = 16'd555;
            @(negedge clk);
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_bcd", 32'(out_bcd), 32'h01234);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_release_busy", {31'b0, busy}, 32'd0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd4321;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_bcd", 32'(out_bcd), 32'd0);
        convert(16'd777, 20'h00777, "after_rst");

        // Streaming with in_valid and out_ready held high.
        vals[0] = 16'd100; vals[1] = 16'd200; vals[2] = 16'd300;
        exps[0] = 20'h00100; exps[1] = 20'h00200; exps[2] = 20'h00300;
        @(negedge clk);
        idx = 0;
        nres = 0;
        prev = 1'b0;
        in_valid  = 1'b1;
        in_data   = vals[0];
        out_ready = 1'b1;
        acc_pending = in_ready;
        for (int c = 0; c < 200 && nres < 3; c++) begin
            @(negedge clk);
            if (out_valid && !prev) begin
                rise[nres] = c;
                check("stream_bcd", 32'(out_bcd), 32'(exps[nres]));
                nres++;
            end
            prev = out_valid;
            if (acc_pending) begin
                idx++;
                if (idx < 3) in_data = vals[idx];
                else in_valid = 1'b0;
            end
            acc_pending = in_valid && in_ready;
        end
        check("stream_count", 32'(nres), 32'd3);
        if (nres == 3) begin
            check("stream_gap01", 32'(rise[1] - rise[0]), 32'(SPACING));
            check("stream_gap12", 32'(rise[2] - rise[1]), 32'(SPACING));
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("end_idle_busy", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/double_dabble_sequencer.md
Name: double_dabble_sequencer

Overview:
- Iterative binary-to-BCD converter. One shared bank of BCD_DIGITS double-dabble adjust cells processes one bit per clock.
- Each adjust cell adds 3 to a digit greater than 4.
- Sits between a binary producer (counters, ADC results) and decimal display or UART formatting logic.
- Uses a valid/ready handshake on both sides and holds one conversion at a time.

Parameters:
- BIN_WIDTH, 16: width of the binary input, legal range 1..32.
- BCD_DIGITS, 5: number of BCD digits output. Elaboration fails ($error) if 10^BCD_DIGITS <= 2^BIN_WIDTH - 1.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  BIN_WIDTH  unsigned binary value.
- out_valid  output  1  out_bcd holds a completed result.
- out_ready  input  1  consumer takes the result.
- out_bcd  output  4*BCD_DIGITS  packed BCD; digit 0 (ones) is in bits [3:0].
- busy  output  1  high in SHIFT and DONE.

Behaviour:
- Internal state:
  - Shift register sr of width 4*BCD_DIGITS+BIN_WIDTH: BCD field on top, binary field on bottom.
  - Bit counter cnt of width $clog2(BIN_WIDTH+1).
  - FSM with states IDLE, SHIFT, DONE.
- Reset, taking effect on the edge where rst=1:
  - State goes to IDLE; sr=0; cnt=0.
  - in_ready=1, out_valid=0, busy=0, out_bcd=0.
  - rst overrides everything. A conversion in progress is discarded with no output, and an in-flight handshake is ignored.
- IDLE:
  - in_ready=1.
  - On the accept edge E0 (in_valid & in_ready): sr <= {0, in_data}, cnt <= BIN_WIDTH, go to SHIFT.
  - in_data is sampled only at E0; later changes to it are ignored.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge: every BCD digit of sr is passed through the adjust (+3 if >4); the adjusted vector is shifted left by 1, with zero shifted into the LSB; cnt decrements.
  - When cnt==1 on an edge, that edge performs the final shift and moves to DONE.
  - Exactly BIN_WIDTH shifts are performed, on edges E1..E_BIN_WIDTH.
  - in_valid is ignored throughout.
- DONE:
  - out_valid=1; out_bcd = BCD field of sr, held stable until the handshake.
  - On the edge where out_ready=1, go to IDLE.
  - If out_ready stays low, the state, result and out_valid are held indefinitely.
- Latency: out_valid is first high in the cycle after edge E_BIN_WIDTH.
- Throughput without the optional feature: one conversion per BIN_WIDTH+2 cycles.
- Digit arithmetic: each digit is 4 bits; the adjusted value never exceeds 12, so there is no carry between digits.
- out_bcd is driven from sr in all states. Only the DONE value is meaningful to consumers.
- Edge cases:
  - in_data=0 gives all-zero digits.
  - in_data=2^BIN_WIDTH-1 must convert exactly.
  - BIN_WIDTH=1 gives 1 SHIFT cycle.

Optional Feature:
- Macro: DOUBLE_DABBLE_SEQ_BACK_TO_BACK_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - If out_ready & in_valid on the same edge: the result is retired and the new in_data is loaded into sr. cnt becomes BIN_WIDTH and the state goes directly to SHIFT, with no IDLE cycle.
  - If out_ready and no in_valid: go to IDLE.
  - Throughput becomes one conversion per BIN_WIDTH+1 cycles.
- Undefined: in_ready=0 in DONE, exactly as in Behaviour.

Test Plan:
- Reset, then idle for 3 cycles -> in_ready=1, out_valid=0, busy=0, out_bcd=0.
- in_data=16'd65535, out_ready held 1 -> out_valid rises 16 edges after accept, out_bcd=20'h65535; busy drops the cycle after the handshake.
- in_data=0, then 16'd9, then 16'd10, then 16'd40960 -> out_bcd=20'h00000, 20'h00009, 20'h00010, 20'h40960.
- in_data=16'd1234, out_ready=0 for 10 cycles after out_valid -> out_bcd=20'h01234 stable and out_valid=1 throughout. in_valid pulses during SHIFT/DONE are not accepted (with the macro undefined).
- Accept 16'd4321, assert rst at cycle 8 of SHIFT -> next cycle is IDLE with reset outputs; a fresh 16'd777 then converts to 20'h00777.
- With DOUBLE_DABBLE_SEQ_BACK_TO_BACK_EN, in_valid held 1 with values 100, 200, 300 and out_ready=1 -> results 20'h00100, 20'h00200, 20'h00300 with out_valid rising every 17 cycles and no IDLE cycle. Without the macro the spacing is 18 cycles.
